// File: rtl/echo_capture.sv
// Echo/sense line recorder: stores alternating phase durations in clk cycles
// into a small RAM that the host reads back once the capture is done.
module echo_capture #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WIDTH      = 32,
   parameter int TIMEOUT    = 4194304
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  sense,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  first_level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
   localparam logic [DEPTH_LOG2:0] LAST = (DEPTH_LOG2 + 1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      MEASURE,
      FINISHED
   } state_t;

   state_t state, state_n;

   logic s1, s2, s3;
   logic toggle;

   logic [WIDTH-1:0]      cnt, cnt_n;
   logic [DEPTH_LOG2:0]   count_n;
   logic                  full_n;
   logic                  first_n;
   logic                  we;

   logic [WIDTH-1:0] mem [DEPTH];

   assign toggle = s2 ^ s3;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      count_n = count;
      full_n  = full;
      first_n = first_level;
      we      = 1'b0;
      if (arm) begin
         state_n = WAIT_FIRST;
         cnt_n   = '0;
         count_n = '0;
         full_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            WAIT_FIRST: begin
               if (toggle) begin
                  first_n = s2;
                  cnt_n   = WIDTH'(1);
                  state_n = MEASURE;
               end else if (cnt == TMO) begin
                  state_n = FINISHED;
               end else begin
                  cnt_n = cnt + WIDTH'(1);
               end
            end
            MEASURE: begin
               // an edge landing on the timeout cycle still closes its phase
               if (toggle) begin
                  we      = 1'b1;
                  count_n = count + (DEPTH_LOG2 + 1)'(1);
                  cnt_n   = WIDTH'(1);
                  if (count == LAST) begin
                     full_n  = 1'b1;
                     state_n = FINISHED;
                  end
               end else if (cnt == TMO) begin
                  state_n = FINISHED;
               end else begin
                  cnt_n = cnt + WIDTH'(1);
               end
            end
            FINISHED: begin
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         count       <= '0;
         full        <= 1'b0;
         first_level <= 1'b0;
      end else begin
         s1          <= sense;
         s2          <= s1;
         s3          <= s2;
         state       <= state_n;
         cnt         <= cnt_n;
         count       <= count_n;
         full        <= full_n;
         first_level <= first_n;
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem[count[DEPTH_LOG2-1:0]] <= cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

   assign busy = (state == WAIT_FIRST) || (state == MEASURE);
   assign done = (state == FINISHED);

endmodule

// File: tb/tb_echo_capture.sv
// Randomized and directed bench for echo_capture against a model built
// from edge arrival times.
module tb_echo_capture;

   localparam int DL    = 8;
   localparam int W     = 32;
   localparam int T     = 1000;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          sense;
   logic [DL-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          busy;
   logic          done;
   logic          full;
   logic [DL:0]   count;
   logic          first_level;

   always #5 clk = ~clk;

   echo_capture #(
      .DEPTH_LOG2(DL),
      .WIDTH(W),
      .TIMEOUT(T)
   ) dut (
      .clk(clk),
      .rst(rst),
      .arm(arm),
      .sense(sense),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .busy(busy),
      .done(done),
      .full(full),
      .count(count),
      .first_level(first_level)
   );

   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   int   arm_t = 0;
   int   ep[$];
   logic el[$];
   logic fl_m = 1'b0;
   int   last_rise = -1;
   logic done_q = 1'b0;

   // cycle index of the posedge at which done first went high
   always @(negedge clk) begin
      if (done && !done_q) last_rise = cyc;
      done_q = done;
   end

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic do_arm();
      arm = 1'b1;
      arm_t = cyc + 1;
      tick();
      arm = 1'b0;
      check("arm_busy", busy, 1);
      check("arm_done", done, 0);
      check("arm_count", count, 0);
   endtask

   // change driven after posedge c reaches the FSM at posedge c+3
   task automatic flip();
      sense = ~sense;
      ep.push_back(cyc + 3);
      el.push_back(sense);
   endtask

   task automatic verify(string tag);
      int idx;
      int prev;
      int dt;
      bit fm;
      logic [W-1:0] ent[$];
      idx = -1;
      fm = 0;
      prev = 0;
      foreach (ep[i]) if (idx < 0 && ep[i] > arm_t) idx = i;
      if (idx < 0 || ep[idx] > arm_t + T + 1) begin
         dt = arm_t + T + 1;
      end else begin
         fl_m = el[idx];
         prev = ep[idx];
         for (int j = idx + 1; j < ep.size(); j++) begin
            if (ep[j] - prev > T) break;
            ent.push_back(W'(ep[j] - prev));
            prev = ep[j];
            if (ent.size() == DEPTH) begin
               fm = 1;
               break;
            end
         end
         dt = fm ? prev : prev + T;
      end
      while (last_rise <= arm_t && cyc < dt + 10) tick();
      idle(2);
      check($sformatf("%s_done_t", tag), last_rise, dt);
      check($sformatf("%s_done", tag), done, 1);
      check($sformatf("%s_busy", tag), busy, 0);
      check($sformatf("%s_count", tag), count, ent.size());
      check($sformatf("%s_full", tag), full, fm);
      check($sformatf("%s_first", tag), first_level, fl_m);
      for (int k = 0; k < ent.size(); k++) begin
         rd_addr = DL'(k);
         tick();
         check($sformatf("%s_e%0d", tag, k), rd_data, ent[k]);
      end
   endtask

   initial begin
      rst = 1'b1;
      arm = 1'b0;
      sense = 1'b0;
      rd_addr = '0;
      idle(3);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_first", first_level, 0);
      rst = 1'b0;
      fl_m = 1'b0;
      idle(5);

      do_arm();
      verify("quiet");

      do_arm();
      idle(100);
      for (int i = 0; i < 4; i++) begin
         flip();
         if (i < 3) idle(625);
      end
      verify("spaced");

      do_arm();
      idle(7);
      flip();
      idle(1);
      flip();
      idle(10);
      flip();
      verify("pulse");

      do_arm();
      idle(3);
      for (int i = 0; i < 260; i++) begin
         flip();
         idle(4);
      end
      verify("fill");

      do_arm();
      idle(4);
      for (int i = 0; i < 3; i++) begin
         flip();
         idle(30);
      end
      do_arm();
      idle(5);
      flip();
      idle(50);
      flip();
      idle(2);
      check("rearm_done_early", done, 0);
      verify("rearm");

      do_arm();
      idle(T - 2);
      flip();
      idle(T);
      flip();
      verify("edge_at_limit");

      for (int s = 0; s < 8; s++) begin
         int n;
         do_arm();
         if ($urandom_range(0, 3) == 0) idle($urandom_range(T - 4, T));
         else idle($urandom_range(0, 60));
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin
            flip();
            if ($urandom_range(0, 9) == 0) idle($urandom_range(T - 3, T + 3));
            else idle($urandom_range(1, 40));
         end
         verify($sformatf("rnd%0d", s));
      end

      do_arm();
      idle(3);
      for (int i = 0; i < 3; i++) begin
         flip();
         idle(20);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      fl_m = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_count", count, 0);
      check("midrst_first", first_level, 0);
      idle(10);
      flip();
      idle(20);
      flip();
      idle(20);
      check("idle_busy", busy, 0);
      check("idle_count", count, 0);
      check("idle_done", done, 0);

      do_arm();
      idle(9);
      flip();
      idle(17);
      flip();
      idle(3);
      flip();
      verify("after_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/echo_capture.md
Name: echo_capture

Overview:
- Receive-side counterpart to the pulse-sequence driver: records the echo/sense line as a list of phase durations in clk cycles.
- Output is the same per-entry form as the drive pulse memory: entry n = length of phase n, phases alternating in level.
- Sits between the board input pin and the host/analysis logic. The host arms it, waits for done, then reads entries back through a synchronous read port.

Parameters:
- DEPTH_LOG2, 8, log2 of capture memory depth (256 entries).
- WIDTH, 32, width of each duration entry and of the cycle counter.
- TIMEOUT, 4194304, idle cycles (~84 ms at 50 MHz) that end a capture; must be < 2^WIDTH and > 0.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous reset, active-high.
- arm  input  1  single-cycle pulse; starts a new capture.
- sense  input  1  asynchronous echo input from pin.
- rd_addr  input  DEPTH_LOG2  read address.
- rd_data  output  WIDTH  registered read data.
- busy  output  1  high in WAIT_FIRST or MEASURE.
- done  output  1  high in DONE.
- full  output  1  capture ended because memory filled.
- count  output  DEPTH_LOG2+1  number of entries written.
- first_level  output  1  synchronized sense level just after the first edge.

Behaviour:
- Sync: s1 <= sense, s2 <= s1, s3 <= s2; all reset to 0. edge = s2 ^ s3. Input-pin-to-edge latency is 3 cycles.
- Reset (rst=1 on a clk edge): state=IDLE, cnt=0, ptr/count=0, done=0, full=0, busy=0, first_level=0, rd_data=0. Memory contents are not cleared. rst overrides arm.
- States:
  - IDLE: waits for arm.
  - WAIT_FIRST: waits for the first edge.
  - MEASURE: times phases.
  - DONE: holds results until the next arm.
- arm in any state (rst=0): next state WAIT_FIRST, cnt=0, count=0, full=0, done=0. A capture in progress is abandoned. arm takes priority over an edge in the same cycle.
- WAIT_FIRST:
  - On edge: first_level <= s2, cnt <= 1, go to MEASURE. Nothing is written.
  - Otherwise: cnt <= cnt+1; when cnt == TIMEOUT, go to DONE with count=0.
- MEASURE:
  - On edge: mem[count] <= cnt; count <= count+1; cnt <= 1. Edges at cycles t0 and t1 therefore store t1-t0, so the minimum entry is 1.
  - If count+1 == 2^DEPTH_LOG2 on that write, go to DONE with full=1.
  - Otherwise, when there is no edge: cnt <= cnt+1. When cnt == TIMEOUT, go to DONE. The trailing open phase is not stored.
  - An edge and cnt == TIMEOUT in the same cycle: the edge wins and is written.
- DONE: edges ignored; cnt frozen; outputs held.
- Read port: rd_data <= mem[rd_addr] every cycle, 1-cycle latency, valid in any state. Reading the address being written in the same cycle returns the old contents.
- Entries at index >= count are stale and undefined to the host.

Test Plan:
- Reset, arm, then sense toggles at cycles 100, 725, 1350, 1975 (synced timing) and sense held after → entries 625, 625, 625 read back; count=3; first_level=1; after TIMEOUT cycles done=1, busy=0, full=0.
- Arm with sense held low → done=1 after TIMEOUT+1 cycles; count=0; first_level=0.
- 1-cycle pulse: sense high for one cycle, low, then high 10 cycles later → entries 1, then 10 (recorded at the next edge); no edge lost.
- 257 edges spaced 4 cycles apart → done asserted immediately after the 256th write; full=1; count=256; all entries 4; later edges do not alter memory.
- arm pulsed mid-MEASURE after 2 entries, then 2 new edges 50 apart → count restarts; entry 0=50; count=1; done=0 until timeout.
- rst asserted mid-MEASURE → next cycle state IDLE, count=0, busy=0, done=0. Subsequent edges are ignored until arm.
